// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for the west (A) and north (B) edges of an N x N PE mesh.
// Optional macro FEEDER_BUBBLE_CNT_EN enables the STREAM bubble counter on bubble_cnt.

module systolic_skew_lane #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             valid,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             valid_out
);
  logic [DEPTH-1:0][WIDTH-1:0] a_pipe, b_pipe;
  logic [DEPTH-1:0]            vld_pipe;

  // Free-running: zeros shift in whenever nothing is accepted, so idle lanes drain to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_pipe   <= '0;
      b_pipe   <= '0;
      vld_pipe <= '0;
    end else begin
      a_pipe[0]   <= a;
      b_pipe[0]   <= b;
      vld_pipe[0] <= valid;
      for (int s = 1; s < DEPTH; s++) begin
        a_pipe[s]   <= a_pipe[s-1];
        b_pipe[s]   <= b_pipe[s-1];
        vld_pipe[s] <= vld_pipe[s-1];
      end
    end
  end

  assign a_out     = a_pipe[DEPTH-1];
  assign b_out     = b_pipe[DEPTH-1];
  assign valid_out = vld_pipe[DEPTH-1];
endmodule

module systolic_skew_feeder #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_a,
  input  logic [N*WIDTH-1:0] in_b,
  input  logic               in_last,
  output logic [N*WIDTH-1:0] a_edge,
  output logic [N*WIDTH-1:0] b_edge,
  output logic [N-1:0]       lane_valid,
  output logic               busy,
  output logic               done,
  output logic [15:0]        beat_cnt,
  output logic [15:0]        bubble_cnt
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]         state;
  logic [CW-1:0]      flush_cnt;
  logic               accept;
  logic [N*WIDTH-1:0] push_a, push_b;

  assign in_ready = (state != S_FLUSH);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);
  // Non-accept cycles push zero operands: they add nothing inside the PEs.
  assign push_a   = accept ? in_a : '0;
  assign push_b   = accept ? in_b : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    systolic_skew_lane #(.WIDTH(WIDTH), .DEPTH(i + 2)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .a         (push_a[i*WIDTH +: WIDTH]),
      .b         (push_b[i*WIDTH +: WIDTH]),
      .valid     (accept),
      .a_out     (a_edge[i*WIDTH +: WIDTH]),
      .b_out     (b_edge[i*WIDTH +: WIDTH]),
      .valid_out (lane_valid[i])
    );
  end

  // FLUSH lasts N edges so done lines up with the last beat leaving lane N-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          state     <= in_last ? S_FLUSH : S_STREAM;
          flush_cnt <= '0;
        end
        S_STREAM: if (accept && in_last) begin
          state     <= S_FLUSH;
          flush_cnt <= '0;
        end
        S_FLUSH: if (flush_cnt == CW'(N - 1)) begin
          done  <= 1'b1;
          state <= S_IDLE;
        end else begin
          flush_cnt <= flush_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      beat_cnt <= '0;
    else if (accept) begin
      if (state == S_IDLE)
        beat_cnt <= 16'd1;
      else if (beat_cnt != 16'hFFFF)
        beat_cnt <= beat_cnt + 16'd1;
    end
  end

`ifdef FEEDER_BUBBLE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubble_cnt <= '0;
    else if (accept && state == S_IDLE)
      bubble_cnt <= '0;
    else if (state == S_STREAM && !accept && bubble_cnt != 16'hFFFF)
      bubble_cnt <= bubble_cnt + 16'd1;
  end
`else
  assign bubble_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=4, WIDTH=16) with a small 4x4 PE mesh model.
module tb_systolic_skew_feeder;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_a = '0;
  logic [N*W-1:0] in_b = '0;
  logic           in_last = 1'b0;
  logic [N*W-1:0] a_edge, b_edge;
  logic [N-1:0]   lane_valid;
  logic           busy, done;
  logic [15:0]    beat_cnt, bubble_cnt;

  int checks = 0;
  int errors = 0;

`ifdef FEEDER_BUBBLE_CNT_EN
  localparam logic [15:0] EXP_BUB = 16'd1;
`else
  localparam logic [15:0] EXP_BUB = 16'd0;
`endif

  systolic_skew_feeder #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .a_edge(a_edge), .b_edge(b_edge), .lane_valid(lane_valid),
    .busy(busy), .done(done), .beat_cnt(beat_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // PE mesh model: a moves east, b moves south, each PE accumulates a*b.
  logic [31:0] acc [N][N];
  logic [15:0] ar  [N][N];
  logic [15:0] br  [N][N];
  bit mesh_clr = 1'b0;

  always @(negedge clk) begin
    logic [15:0] ai, bi;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ai = (j == 0) ? a_edge[i*W +: W] : ar[i][(j == 0) ? 0 : j-1];
        bi = (i == 0) ? b_edge[j*W +: W] : br[(i == 0) ? 0 : i-1][j];
        if (mesh_clr) begin
          acc[i][j] <= '0; ar[i][j] <= '0; br[i][j] <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + {16'd0, ai} * {16'd0, bi};
          ar[i][j]  <= ai;
          br[i][j]  <= bi;
        end
      end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
  endtask

  task automatic set_beat(input int k, input bit last);
    in_valid = 1'b1; in_last = last;
    for (int i = 0; i < N; i++) begin
      in_a[i*W +: W] = 16'(16*k + i);
      in_b[i*W +: W] = 16'(256 + 16*k + i);
    end
  endtask

  task automatic test_reset;
    idle_in();
    reset = 1'b1;
    step(); step();
    checks++; if (a_edge !== '0)      begin errors++; $display("FAIL reset_a got %h exp 0", a_edge); end
    checks++; if (b_edge !== '0)      begin errors++; $display("FAIL reset_b got %h exp 0", b_edge); end
    checks++; if (lane_valid !== '0)  begin errors++; $display("FAIL reset_valid got %b exp 0", lane_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_beat got %0d exp 0", beat_cnt); end
    checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bubble got %0d exp 0", bubble_cnt); end
    reset = 1'b0;
    step();
  endtask

  // K=4 back to back, last on beat 3.
  task automatic test_back_to_back;
    for (int e = 0; e <= 8; e++) begin
      if (e < 4) set_beat(e, e == 3); else idle_in();
      step();
      for (int i = 0; i < N; i++) begin
        int src; bit v; logic [15:0] ea, eb;
        src = e - 1 - i;
        v  = (src >= 0 && src < 4);
        ea = v ? 16'(16*src + i) : 16'd0;
        eb = v ? 16'(256 + 16*src + i) : 16'd0;
        checks++; if (a_edge[i*W +: W] !== ea) begin errors++; $display("FAIL b2b_a e%0d l%0d got %h exp %h", e, i, a_edge[i*W +: W], ea); end
        checks++; if (b_edge[i*W +: W] !== eb) begin errors++; $display("FAIL b2b_b e%0d l%0d got %h exp %h", e, i, b_edge[i*W +: W], eb); end
        checks++; if (lane_valid[i] !== v)     begin errors++; $display("FAIL b2b_v e%0d l%0d got %b exp %b", e, i, lane_valid[i], v); end
      end
      checks++; if (done !== (e == 7)) begin errors++; $display("FAIL b2b_done e%0d got %b", e, done); end
      checks++; if (busy !== (e <= 6)) begin errors++; $display("FAIL b2b_busy e%0d got %b", e, busy); end
      checks++; if (in_ready !== !(e >= 3 && e <= 6)) begin errors++; $display("FAIL b2b_ready e%0d got %b", e, in_ready); end
    end
    checks++; if (beat_cnt !== 16'd4) begin errors++; $display("FAIL b2b_beat_cnt got %0d exp 4", beat_cnt); end
  endtask

  // K=1 tile, lanes carry 1,2,3,4.
  task automatic test_single_beat;
    for (int e = 0; e <= 5; e++) begin
      if (e == 0) begin
        in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < N; i++) begin
          in_a[i*W +: W] = 16'(i + 1);
          in_b[i*W +: W] = 16'(i + 5);
        end
      end else idle_in();
      step();
      for (int i = 0; i < N; i++) begin
        bit v; logic [15:0] ea;
        v  = (e == 1 + i);
        ea = v ? 16'(i + 1) : 16'd0;
        checks++; if (a_edge[i*W +: W] !== ea) begin errors++; $display("FAIL k1_a e%0d l%0d got %h exp %h", e, i, a_edge[i*W +: W], ea); end
        checks++; if (lane_valid[i] !== v)     begin errors++; $display("FAIL k1_v e%0d l%0d got %b exp %b", e, i, lane_valid[i], v); end
      end
      checks++; if (done !== (e == 4))     begin errors++; $display("FAIL k1_done e%0d got %b", e, done); end
      checks++; if (in_ready !== (e >= 4)) begin errors++; $display("FAIL k1_ready e%0d got %b", e, in_ready); end
    end
    checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL k1_beat_cnt got %0d exp 1", beat_cnt); end
  endtask

  // K=3 with one idle cycle between beat 0 and beat 1.
  task automatic test_bubble;
    int bk [4] = '{0, -1, 1, 2};
    for (int e = 0; e <= 8; e++) begin
      if (e < 4 && bk[e] >= 0) set_beat(bk[e], e == 3); else idle_in();
      step();
      for (int i = 0; i < N; i++) begin
        int src, k; logic [15:0] ea;
        src = e - 1 - i;
        k   = (src >= 0 && src < 4) ? bk[src] : -1;
        ea  = (k >= 0) ? 16'(16*k + i) : 16'd0;
        checks++; if (a_edge[i*W +: W] !== ea) begin errors++; $display("FAIL bub_a e%0d l%0d got %h exp %h", e, i, a_edge[i*W +: W], ea); end
        checks++; if (lane_valid[i] !== (k >= 0)) begin errors++; $display("FAIL bub_v e%0d l%0d got %b", e, i, lane_valid[i]); end
      end
      checks++; if (done !== (e == 7)) begin errors++; $display("FAIL bub_done e%0d got %b", e, done); end
    end
    checks++; if (beat_cnt !== 16'd3)  begin errors++; $display("FAIL bub_beat_cnt got %0d exp 3", beat_cnt); end
    checks++; if (bubble_cnt !== EXP_BUB) begin errors++; $display("FAIL bub_cnt got %0d exp %0d", bubble_cnt, EXP_BUB); end
  endtask

  // K=2 tile, then beat 9 held valid through FLUSH; accepted only once IDLE.
  task automatic test_flush_ignore;
    for (int e = 0; e <= 11; e++) begin
      if (e == 0) set_beat(0, 1'b0);
      else if (e == 1) set_beat(1, 1'b1);
      else if (e <= 6) set_beat(9, e == 6);
      else idle_in();
      step();
      checks++; if (lane_valid[0] !== (e == 1 || e == 2 || e == 7)) begin errors++; $display("FAIL fl_v0 e%0d got %b", e, lane_valid[0]); end
      checks++; if (a_edge[W-1:0] !== ((e == 2) ? 16'd16 : (e == 7) ? 16'd144 : 16'd0)) begin errors++; $display("FAIL fl_a0 e%0d got %h", e, a_edge[W-1:0]); end
      checks++; if (done !== (e == 5 || e == 10)) begin errors++; $display("FAIL fl_done e%0d got %b", e, done); end
      if (e >= 1 && e <= 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready e%0d got %b exp 0", e, in_ready); end
      end
      if (e >= 1 && e <= 5) begin
        checks++; if (beat_cnt !== 16'd2) begin errors++; $display("FAIL fl_beat e%0d got %0d exp 2", e, beat_cnt); end
      end
      if (e == 6) begin
        checks++; if (beat_cnt !== 16'd1) begin errors++; $display("FAIL fl_beat_new got %0d exp 1", beat_cnt); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL fl_busy_new got %b exp 1", busy); end
      end
      if (e == 10) begin
        checks++; if (a_edge[3*W +: W] !== 16'd147) begin errors++; $display("FAIL fl_a3 got %h exp 93", a_edge[3*W +: W]); end
      end
    end
  endtask

  // Reset two cycles into a K=4 tile, then a fresh K=2 tile.
  task automatic test_reset_mid;
    set_beat(0, 1'b0); step();
    set_beat(1, 1'b0); step();
    idle_in();
    reset = 1'b1; #1;
    checks++; if (a_edge !== '0 || b_edge !== '0) begin errors++; $display("FAIL rm_edges got %h %h exp 0", a_edge, b_edge); end
    checks++; if (lane_valid !== '0) begin errors++; $display("FAIL rm_valid got %b exp 0", lane_valid); end
    checks++; if (busy !== 1'b0 || beat_cnt !== 16'd0) begin errors++; $display("FAIL rm_state got busy %b cnt %0d", busy, beat_cnt); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done got %b exp 0", done); end
    reset = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      if (e == 0) set_beat(5, 1'b0); else if (e == 1) set_beat(6, 1'b1); else idle_in();
      step();
      for (int i = 0; i < N; i++) begin
        int src; logic [15:0] ea;
        src = e - 1 - i;
        ea  = (src == 0) ? 16'(80 + i) : (src == 1) ? 16'(96 + i) : 16'd0;
        checks++; if (a_edge[i*W +: W] !== ea) begin errors++; $display("FAIL rm_a e%0d l%0d got %h exp %h", e, i, a_edge[i*W +: W], ea); end
      end
      checks++; if (done !== (e == 5)) begin errors++; $display("FAIL rm_done2 e%0d got %b", e, done); end
    end
    checks++; if (beat_cnt !== 16'd2) begin errors++; $display("FAIL rm_beat_cnt got %0d exp 2", beat_cnt); end
  endtask

  // A = I, B = [1..16] row-major: every PE must end with C = B.
  task automatic test_mesh;
    mesh_clr = 1'b1;
    @(negedge clk); #1;
    mesh_clr = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; in_last = (k == N - 1);
      for (int i = 0; i < N; i++) begin
        in_a[i*W +: W] = (i == k) ? 16'd1 : 16'd0;
        in_b[i*W +: W] = 16'(4*k + i + 1);
      end
      step();
    end
    idle_in();
    for (int c = 0; c < 16; c++) step();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (acc[i][j] !== 32'(4*i + j + 1)) begin
          errors++; $display("FAIL mesh_c%0d%0d got %0d exp %0d", i, j, acc[i][j], 4*i + j + 1);
        end
      end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_beat();
    test_bubble();
    test_flush_ignore();
    test_reset_mid();
    test_mesh();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
